// File: rtl/sram_access_seq.sv
// Single-bank SRAM access sequencer: one request in flight, one-cycle
// chip-select strobe, LAT-cycle read wait, then a one-cycle response pulse.
module sram_access_seq #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 256,
    parameter int MASK_W = 32,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [MASK_W-1:0] req_wmask,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              busy,
    output logic              sram_csb,
    output logic              sram_web,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    output logic [MASK_W-1:0] sram_wmask,
    input  logic [DATA_W-1:0] sram_dout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] cnt_q;
    logic       write_q;
    logic       accept;
    logic       wait_done;

    assign accept    = req_valid & req_ready;
    assign wait_done = (state_q == WAIT) && (cnt_q == 4'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = ACCESS;
            ACCESS:  state_d = WAIT;
            WAIT:    if (cnt_q == 4'd0) state_d = RESP;
            RESP:    state_d = accept ? ACCESS : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == IDLE) || (state_q == RESP);
        busy       = (state_q == ACCESS) || (state_q == WAIT);
        resp_valid = (state_q == RESP);
        sram_csb   = (state_q != ACCESS);
        sram_web   = !((state_q == ACCESS) && write_q);
    end

    // Request latch doubles as the SRAM-facing address/data/mask registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            write_q    <= 1'b0;
            sram_addr  <= '0;
            sram_din   <= '0;
            sram_wmask <= '0;
        end else if (accept) begin
            write_q    <= req_write;
            sram_addr  <= req_addr;
            sram_din   <= req_wdata;
            sram_wmask <= req_wmask;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else if (state_q == ACCESS) begin
            cnt_q <= CNT_INIT;
        end else if ((state_q == WAIT) && (cnt_q != 4'd0)) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    // Read data is only captured on reads; writes leave the last value intact.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_rdata <= '0;
        end else if (wait_done && !write_q) begin
            resp_rdata <= sram_dout;
        end
    end

endmodule

// File: tb/tb_sram_access_seq.sv
// Randomized bench for sram_access_seq: timeline-based reference model
// plus a behavioural SRAM that only presents valid data on the capture cycle.
module tb_sram_access_seq;

    localparam int LAT  = 3;
    localparam int AW   = 5;
    localparam int DW   = 256;
    localparam int MW   = 32;
    localparam int NCYC = 3000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [MW-1:0] req_wmask;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          busy;
    logic          sram_csb;
    logic          sram_web;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din;
    logic [MW-1:0] sram_wmask;
    logic [DW-1:0] sram_dout;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sram_access_seq #(
        .ADDR_W(AW), .DATA_W(DW), .MASK_W(MW), .LAT(LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .busy(busy), .sram_csb(sram_csb), .sram_web(sram_web),
        .sram_addr(sram_addr), .sram_din(sram_din),
        .sram_wmask(sram_wmask), .sram_dout(sram_dout)
    );

    task automatic check(input string tag, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_line();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                            input logic [DW-1:0] nw,
                                            input logic [MW-1:0] m);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < MW; b++) if (m[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    // Reference model: memory image and timeline of the one in-flight request
    logic [DW-1:0] ref_mem [32];
    logic [DW-1:0] sram_mem[32];
    bit            have_p;
    int            p_acc;
    bit            p_write;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wdata;
    logic [MW-1:0] p_mask;
    logic [DW-1:0] p_rexp;
    logic [DW-1:0] exp_rdata;
    bit            just_reset;
    int            rd_cycle;
    logic [AW-1:0] rd_addr;

    initial begin
        bit acc_cyc, resp_cyc, ready;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wmask = '0;
        sram_dout = '0;
        for (int i = 0; i < 32; i++) begin
            ref_mem[i]  = rnd_line();
            sram_mem[i] = ref_mem[i];
        end
        ref_mem[5]  = {32{8'hA5}};
        sram_mem[5] = {32{8'hA5}};
        have_p     = 1'b0;
        p_acc      = 0;
        p_write    = 1'b0;
        p_addr     = '0;
        p_wdata    = '0;
        p_mask     = '0;
        p_rexp     = '0;
        exp_rdata  = '0;
        just_reset = 1'b1;
        rd_cycle   = -1;
        rd_addr    = '0;
        @(posedge clk);

        for (int t = 0; t < NCYC; t++) begin
            #1;
            acc_cyc  = have_p && (t == p_acc + 1);
            resp_cyc = have_p && (t == p_acc + LAT + 2);
            ready    = !have_p || resp_cyc;
            check("csb", DW'(sram_csb), DW'(!acc_cyc));
            check("web", DW'(sram_web), DW'(!(acc_cyc && p_write)));
            check("resp_valid", DW'(resp_valid), DW'(resp_cyc));
            check("req_ready", DW'(req_ready), DW'(ready));
            check("busy", DW'(busy),
                  DW'(have_p && t > p_acc && t < p_acc + LAT + 2));
            check("resp_rdata", resp_rdata, exp_rdata);
            if (acc_cyc) begin
                check("sram_addr", DW'(sram_addr), DW'(p_addr));
                check("sram_din", sram_din, p_wdata);
                check("sram_wmask", DW'(sram_wmask), DW'(p_mask));
            end
            if (just_reset) begin
                check("rst_addr", DW'(sram_addr), '0);
                check("rst_din", sram_din, '0);
                check("rst_wmask", DW'(sram_wmask), '0);
            end

            // Behavioural SRAM reacting to what the DUT actually drives
            if (sram_csb === 1'b0) begin
                if (sram_web === 1'b0)
                    sram_mem[sram_addr] = merge(sram_mem[sram_addr],
                                                sram_din, sram_wmask);
                else begin
                    rd_cycle = t + LAT;
                    rd_addr  = sram_addr;
                end
            end
            sram_dout = (t == rd_cycle) ? sram_mem[rd_addr] : rnd_line();

            // Stimulus for this cycle
            rst_n     = (t < 60) ? 1'b1 : ($urandom_range(0, 59) != 0);
            req_valid = (t < 10) ? 1'b0 : ($urandom_range(0, 2) != 0);
            req_write = $urandom_range(0, 1) == 1;
            req_addr  = AW'($urandom);
            req_wdata = rnd_line();
            req_wmask = ($urandom_range(0, 7) == 0) ? '0 : MW'($urandom);
            if (t == 10) begin
                req_valid = 1'b1;
                req_write = 1'b0;
                req_addr  = 5'd5;
            end else if (t == 20) begin
                req_valid = 1'b1;
                req_write = 1'b1;
                req_addr  = 5'd31;
                req_wmask = 32'h0000_FFFF;
            end else if (t >= 30 && t < 45) begin
                req_valid = 1'b1;
            end

            // Advance the model across the edge that ends cycle t
            if (!rst_n) begin
                have_p     = 1'b0;
                exp_rdata  = '0;
                just_reset = 1'b1;
                rd_cycle   = -1;
            end else begin
                just_reset = 1'b0;
                if (have_p && t == p_acc + LAT + 1 && !p_write)
                    exp_rdata = p_rexp;
                if (resp_cyc) have_p = 1'b0;
                if (req_valid && ready) begin
                    have_p  = 1'b1;
                    p_acc   = t;
                    p_write = req_write;
                    p_addr  = req_addr;
                    p_wdata = req_wdata;
                    p_mask  = req_wmask;
                    if (req_write)
                        ref_mem[req_addr] = merge(ref_mem[req_addr],
                                                  req_wdata, req_wmask);
                    else
                        p_rexp = ref_mem[req_addr];
                end
            end
            @(posedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
